// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO of arbitrary depth with occupancy count, programmable
// almost-full/almost-empty flags, overflow/underflow pulses and optional FWFT read.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1,
    parameter bit FWFT       = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]         count_reg, count_next;
    logic                  full_reg, empty_reg;
    logic                  almost_full_reg, almost_empty_reg;
    logic                  overflow_reg, underflow_reg;
    logic [DATA_WIDTH-1:0] dout_reg;
    logic                  rd_accept, wr_accept;

    // A full FIFO still takes a write when the same cycle frees a slot.
    always_comb begin
        rd_accept   = rd_en && !empty_reg;
        wr_accept   = wr_en && (!full_reg || rd_accept);

        wr_ptr_next = wr_ptr_reg;
        if (wr_accept) begin
            wr_ptr_next = (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + AW'(1);
        end

        rd_ptr_next = rd_ptr_reg;
        if (rd_accept) begin
            rd_ptr_next = (rd_ptr_reg == LAST_IDX) ? '0 : rd_ptr_reg + AW'(1);
        end

        count_next = count_reg;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage is not reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
            dout_reg         <= '0;
        end else begin
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            count_reg        <= count_next;
            full_reg         <= (count_next == DEPTH_C);
            empty_reg        <= (count_next == '0);
            almost_full_reg  <= (count_next >= AF_C);
            almost_empty_reg <= (count_next <= AE_C);
            overflow_reg     <= wr_en && !wr_accept;
            underflow_reg    <= rd_en && !rd_accept;
            if (rd_accept) begin
                dout_reg <= mem[rd_ptr_reg];
            end
        end
    end

    // In FWFT mode the head is shown directly; dout_reg keeps the last popped word.
    generate
        if (FWFT) begin : g_fwft
            assign dout = empty_reg ? dout_reg : mem[rd_ptr_reg];
        end else begin : g_std
            assign dout = dout_reg;
        end
    endgenerate

    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: a DEPTH=4 standard-read FIFO and a DEPTH=5 FWFT FIFO.
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_wr_en, a_rd_en;
    logic [7:0] a_din, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [2:0] a_count;

    logic       b_rst_n, b_wr_en, b_rd_en;
    logic [7:0] b_din, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(a_rst_n), .wr_en(a_wr_en), .din(a_din), .rd_en(a_rd_en),
        .dout(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(b_rst_n), .wr_en(b_wr_en), .din(b_din), .rd_en(b_rd_en),
        .dout(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic a_op(input logic wr, input logic rd, input logic [7:0] d);
        a_wr_en = wr; a_rd_en = rd; a_din = d;
        @(posedge clk); #1;
        a_wr_en = 1'b0; a_rd_en = 1'b0;
    endtask

    task automatic b_op(input logic wr, input logic rd, input logic [7:0] d);
        b_wr_en = wr; b_rd_en = rd; b_din = d;
        @(posedge clk); #1;
        b_wr_en = 1'b0; b_rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] wdata [4];
        logic [7:0] fdata [4];
        wdata = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        fdata = '{8'h22, 8'h33, 8'h44, 8'h55};

        a_rst_n = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_din = '0;
        b_rst_n = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_din = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_empty",  32'(a_empty), 1);
        check("rst_ae",     32'(a_ae),    1);
        check("rst_count",  32'(a_count), 0);
        check("rst_dout",   32'(a_dout),  0);
        check("rst_full",   32'(a_full),  0);
        check("rst_af",     32'(a_af),    0);
        check("rst_ovf",    32'(a_ovf),   0);
        check("rst_unf",    32'(a_unf),   0);
        check("b_rst_empty", 32'(b_empty), 1);
        check("b_rst_dout",  32'(b_dout),  0);
        check("b_rst_flags", 32'({b_full, b_af, b_ae, b_ovf, b_unf}), 32'b00100);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill to full, then overflow
        for (int i = 0; i < 4; i++) begin
            a_op(1'b1, 1'b0, wdata[i]);
            check("wr_count", 32'(a_count), 32'(i + 1));
            check("wr_af",    32'(a_af),    (i + 1 >= 3) ? 1 : 0);
            check("wr_full",  32'(a_full),  (i + 1 == 4) ? 1 : 0);
            check("wr_ae",    32'(a_ae),    (i + 1 <= 1) ? 1 : 0);
        end
        a_op(1'b1, 1'b0, 8'hE5);
        check("ovf_pulse", 32'(a_ovf),   1);
        check("ovf_count", 32'(a_count), 4);
        a_op(1'b0, 1'b0, 8'h00);
        check("ovf_clear", 32'(a_ovf),   0);

        // Drain, then underflow
        for (int i = 0; i < 4; i++) begin
            a_op(1'b0, 1'b1, 8'h00);
            check("rd_dout",  32'(a_dout),  32'(wdata[i]));
            check("rd_count", 32'(a_count), 32'(3 - i));
        end
        a_op(1'b0, 1'b1, 8'h00);
        check("unf_pulse", 32'(a_unf),   1);
        check("unf_dout",  32'(a_dout),  32'h0D4);
        check("unf_empty", 32'(a_empty), 1);
        a_op(1'b0, 1'b0, 8'h00);
        check("unf_clear", 32'(a_unf),   0);

        // Simultaneous write+read at full and at empty
        a_op(1'b1, 1'b0, 8'h11);
        a_op(1'b1, 1'b0, 8'h22);
        a_op(1'b1, 1'b0, 8'h33);
        a_op(1'b1, 1'b0, 8'h44);
        check("fill_full", 32'(a_full), 1);
        a_op(1'b1, 1'b1, 8'h55);
        check("wrrd_full_dout",  32'(a_dout),  32'h011);
        check("wrrd_full_count", 32'(a_count), 4);
        check("wrrd_full_ovf",   32'(a_ovf),   0);
        for (int i = 0; i < 4; i++) begin
            a_op(1'b0, 1'b1, 8'h00);
            check("drain_dout", 32'(a_dout), 32'(fdata[i]));
        end
        check("drain_empty", 32'(a_empty), 1);
        a_op(1'b1, 1'b1, 8'h66);
        check("wrrd_empty_unf",   32'(a_unf),   1);
        check("wrrd_empty_count", 32'(a_count), 1);
        check("wrrd_empty_dout",  32'(a_dout),  32'h055);
        a_op(1'b0, 1'b1, 8'h00);
        check("wrrd_empty_read",  32'(a_dout),  32'h066);

        // Asynchronous reset mid-stream
        a_op(1'b1, 1'b0, 8'h71);
        a_op(1'b1, 1'b0, 8'h72);
        a_op(1'b1, 1'b0, 8'h73);
        check("pre_rst_count", 32'(a_count), 3);
        #3;
        a_rst_n = 1'b0;
        #1;
        check("arst_count", 32'(a_count), 0);
        check("arst_empty", 32'(a_empty), 1);
        check("arst_dout",  32'(a_dout),  0);
        check("arst_flags", 32'({a_full, a_af, a_ae}), 32'b001);
        #2;
        a_rst_n = 1'b1;
        @(posedge clk); #1;
        a_op(1'b1, 1'b0, 8'h7A);
        a_op(1'b0, 1'b1, 8'h00);
        check("post_rst_dout", 32'(a_dout), 32'h07A);

        // FWFT, DEPTH=5: head visible as soon as empty drops, pointers wrap
        b_op(1'b1, 1'b0, 8'h30);
        check("b_first_empty", 32'(b_empty), 0);
        check("b_first_dout",  32'(b_dout),  32'h030);
        check("b_first_count", 32'(b_count), 1);
        b_op(1'b1, 1'b0, 8'h31);
        b_op(1'b1, 1'b0, 8'h32);
        for (int k = 3; k < 12; k++) begin
            b_wr_en = 1'b1; b_rd_en = 1'b1; b_din = 8'(8'h30 + k);
            check("b_head", 32'(b_dout), 32'(8'h30 + k - 3));
            @(posedge clk); #1;
            b_wr_en = 1'b0; b_rd_en = 1'b0;
            check("b_count", 32'(b_count), 3);
        end
        for (int j = 9; j < 12; j++) begin
            check("b_drain", 32'(b_dout), 32'(8'h30 + j));
            b_op(1'b0, 1'b1, 8'h00);
        end
        check("b_empty", 32'(b_empty), 1);
        check("b_hold",  32'(b_dout),  32'h03B);
        b_op(1'b0, 1'b1, 8'h00);
        check("b_unf",      32'(b_unf),  1);
        check("b_unf_hold", 32'(b_dout), 32'h03B);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
